key_input_ctrl: RTL and testbench
=================================

// Module: key_input_ctrl
// PURPOSE
//  Front end for the four Tetris operation buttons (up/down/left/right), upstream of the grid controller.
//  Synchronises raw pushbutton inputs into vga_clk, debounces them and turns each press into a request.
//  Requests are held until the next end-of-frame, then issued as one-cycle pulses on op_keys,
//  so the grid controller sees at most one move per key per frame, fully synchronous to vga_clk.
// PARAMETERS
//  NUM_KEYS         4        number of buttons; bit index = key id
//  DEBOUNCE_CYCLES  250000   cycles input must differ from stable state before accepted (10 ms @ 25 MHz)
//  CNT_W            18       debounce counter width; must hold DEBOUNCE_CYCLES-1
//  REPEAT_DELAY     20       frames held before first auto-repeat (KEY_AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    6        frames between subsequent auto-repeats (KEY_AUTO_REPEAT_EN only)
// PORTS
//  vga_clk      in   1         pixel clock, all logic on posedge
//  rst          in   1         asynchronous, active-high reset
//  keys_raw     in   NUM_KEYS  raw button levels, asynchronous, 1 = pressed
//  draw_finish  in   1         end-of-frame level from VGA timing; rising edge = frame boundary
//  op_keys      out  NUM_KEYS  one-cycle move request pulses, registered
//  keys_level   out  NUM_KEYS  debounced button state, registered
// BEHAVIOUR
//  - Reset (async, rst=1): sync FFs, stable state, counters, pending, op_keys, keys_level all 0; draw_finish_d 0.
//  - Sync: 2-FF synchroniser per key; sync output feeds debounce; raw never used elsewhere.
//  - Debounce per key: sync==stable -> cnt<=0. sync!=stable -> cnt++; when cnt==DEBOUNCE_CYCLES-1
//    -> stable<=sync, cnt<=0. Glitch shorter than DEBOUNCE_CYCLES never changes stable.
//  - keys_level = stable. Press event = stable 0->1 (one cycle). Release generates nothing.
//  - frame_edge = draw_finish & ~draw_finish_d (draw_finish_d registered each cycle).
//  - pending[i] set on press event; multiple presses within one frame collapse to one request.
//  - On frame_edge cycle: op_keys <= pending | press_now; pending <= 0. Press coinciding with
//    frame_edge is issued in that pulse, not carried to next frame.
//  - Otherwise op_keys <= 0. Pulse width exactly 1 cycle; latency press->pulse = next frame_edge +1 cycle.
//  - Keys independent; simultaneous opposite keys (up+down) both issued; arbitration is downstream.
//  - draw_finish held high many cycles: only one frame_edge. Edge during reset ignored.
//  - Reset mid-frame: pending requests discarded; button held through reset re-debounced from 0
//    and produces a press event DEBOUNCE_CYCLES+2 cycles after rst falls.
// CONFIGURATION
//  KEY_AUTO_REPEAT_EN defined: per-key frame counter (width >= clog2(REPEAT_DELAY+1)), cleared
//    while stable=0 or on press event; increments on frame_edge while stable=1. At count==REPEAT_DELAY
//    and every REPEAT_PERIOD frames after, pending set for that key (issued on following frame_edge).
//  Not defined: no repeat counters; held key yields exactly one op_keys pulse per press.
// STRUCTURE
//  Package key_input_pkg: KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, NUM_KEYS default,
//    debounce/repeat default constants.
//  Sub-module key_debounce (sync + debounce + press-edge for one key), instantiated NUM_KEYS times
//    via generate; frame-edge, pending and repeat logic stay in key_input_ctrl.
// TESTING (bench uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=3, REPEAT_PERIOD=2)
//  1 keys_raw[2] high 3 cycles then low -> keys_level stays 0, no op_keys pulse ever.
//  2 keys_raw[0] high 20 cycles, draw_finish rises 40 cycles later -> keys_level[0]=1 after 10 cycles;
//    op_keys=4'b0001 for exactly 1 cycle, cycle after frame_edge.
//  3 Press key1 twice (debounced) within one frame -> single op_keys=4'b0010 pulse at frame end.
//  4 Press key3 settling on same cycle as frame_edge -> op_keys=4'b1000 that frame, none next frame.
//  5 Key0 pending, assert rst mid-frame -> op_keys and pending 0 async; next frame_edge gives no pulse.
//  6 KEY_AUTO_REPEAT_EN, hold key2 for 10 frames -> pulses on press frame, then frames +4, +6, +8, +10;
//    without macro -> only the first pulse.

Source files
------------

// File: rtl/key_input_pkg.sv
// Shared constants for the Tetris button front end: key ids and default timing values.
// Imported by key_debounce and key_input_ctrl.
package key_input_pkg;

    typedef enum logic [1:0] {
        KEY_UP    = 2'd0,
        KEY_DOWN  = 2'd1,
        KEY_LEFT  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_id_e;

    localparam int NUM_KEYS_DEF        = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int CNT_W_DEF           = 18;
    localparam int REPEAT_DELAY_DEF    = 20;
    localparam int REPEAT_PERIOD_DEF   = 6;

    // Width of a per-key frame counter that must reach the repeat delay.
    function automatic int rep_cnt_width(input int delay);
        return (delay < 1) ? 1 : $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button lane: 2-FF synchroniser, counter-based debounce and a one-cycle press pulse.
// The press pulse is high in the first cycle the debounced level reads 1.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, then accept a new level only after it persists for the full debounce window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            press_r  <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_DONE) begin
                stable_r <= sync2_r;
                press_r  <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign level = stable_r;
    assign press = press_r;

endmodule

// File: rtl/key_input_ctrl.sv
// Button front end: debounced presses are held as requests and released as one-cycle op_keys
// pulses on each end-of-frame. Optional auto-repeat for held keys under `KEY_AUTO_REPEAT_EN.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
`ifdef KEY_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic                vga_clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                draw_finish,
    output logic [NUM_KEYS-1:0] op_keys,
    output logic [NUM_KEYS-1:0] keys_level
);

    logic [NUM_KEYS-1:0] level_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] rep_hit_s;
    logic [NUM_KEYS-1:0] pending_r;
    logic [NUM_KEYS-1:0] pending_next_s;
    logic [NUM_KEYS-1:0] op_keys_r;
    logic [NUM_KEYS-1:0] op_next_s;
    logic                draw_finish_d_r;
    logic                frame_edge_s;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (vga_clk),
            .rst    (rst),
            .key_raw(keys_raw[g]),
            .level  (level_s[g]),
            .press  (press_s[g])
        );
    end

    assign frame_edge_s = draw_finish & ~draw_finish_d_r;

`ifdef KEY_AUTO_REPEAT_EN
    localparam int REP_W = rep_cnt_width(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY);
    // After a repeat fires, restart so the next hit lands REPEAT_PERIOD frames later.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [REP_W-1:0] rep_cnt_r [NUM_KEYS];

    // Count frames while a key stays held; a fresh press or release restarts the count.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                rep_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (!level_s[i] || press_s[i]) begin
                    rep_cnt_r[i] <= '0;
                end else if (frame_edge_s) begin
                    rep_cnt_r[i] <= (rep_cnt_r[i] == REP_LAST) ? REP_RELOAD
                                  : rep_cnt_r[i] + {{(REP_W-1){1'b0}}, 1'b1};
                end else begin
                    rep_cnt_r[i] <= rep_cnt_r[i];
                end
            end
        end
    end

    // A key whose count sits at the repeat point re-arms its request on this frame edge.
    always_comb begin
        rep_hit_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rep_hit_s[i] = level_s[i] && (rep_cnt_r[i] == REP_LAST);
        end
    end
`else
    assign rep_hit_s = '0;
`endif

    // Frame edge releases collected requests (including a press in this very cycle).
    always_comb begin
        pending_next_s = pending_r;
        op_next_s      = '0;
        if (frame_edge_s) begin
            op_next_s      = pending_r | press_s;
            pending_next_s = rep_hit_s;
        end else begin
            op_next_s      = '0;
            pending_next_s = pending_r | press_s;
        end
    end

    // Request, pulse and frame-edge detector registers.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            pending_r       <= '0;
            op_keys_r       <= '0;
            draw_finish_d_r <= 1'b0;
        end else begin
            pending_r       <= pending_next_s;
            op_keys_r       <= op_next_s;
            draw_finish_d_r <= draw_finish;
        end
    end

    assign op_keys    = op_keys_r;
    assign keys_level = level_s;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl: expected op_keys pulses (value and cycle) are queued
// when each frame edge is driven and matched against every nonzero op_keys observed.
module tb_key_input_ctrl;
    import key_input_pkg::*;

    localparam int DB = 8;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic       vga_clk = 1'b0;
    logic       rst;
    logic       draw_finish;
    logic [3:0] keys_raw;
    logic [3:0] op_keys;
    logic [3:0] keys_level;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mark;
    exp_t sb_q[$];

    key_input_ctrl #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4)
`ifdef KEY_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (3),
        .REPEAT_PERIOD  (2)
`endif
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .keys_raw   (keys_raw),
        .draw_finish(draw_finish),
        .op_keys    (op_keys),
        .keys_level (keys_level)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // Raise draw_finish now (caller is at a negedge) and hold it for several cycles.
    task automatic frame(input logic [3:0] exp);
        exp_t e;
        draw_finish = 1'b1;
        if (exp != 4'b0000) begin
            e.cyc = cyc + 1;
            e.val = exp;
            sb_q.push_back(e);
        end
        tick(6);
        draw_finish = 1'b0;
        tick(4);
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (!rst && op_keys != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", {28'd0, op_keys}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("pulse_value", {28'd0, op_keys}, {28'd0, e.val});
                check_val("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp;
        rst         = 1'b1;
        keys_raw    = 4'b0000;
        draw_finish = 1'b0;
        tick(3);
        check_val("reset_op_keys", {28'd0, op_keys}, 32'd0);
        check_val("reset_level", {28'd0, keys_level}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Short glitch on LEFT never becomes a level or a request.
        keys_raw[KEY_LEFT] = 1'b1;
        tick(3);
        keys_raw[KEY_LEFT] = 1'b0;
        for (int i = 0; i < DB + 4; i++) begin
            tick(1);
            check_val("glitch_level", {28'd0, keys_level}, 32'd0);
        end
        frame(4'b0000);

        // Single UP press: level timing, then one pulse at the frame edge.
        mark = cyc;
        keys_raw[KEY_UP] = 1'b1;
        tick(DB + 1);
        check_val("up_level_before", {28'd0, keys_level}, 32'd0);
        check_val("up_level_cycle", cyc - mark, DB + 1);
        tick(1);
        check_val("up_level_after", {28'd0, keys_level}, 32'h1);
        tick(20 - (DB + 2));
        keys_raw[KEY_UP] = 1'b0;
        tick(40);
        check_val("up_released", {28'd0, keys_level}, 32'd0);
        frame(4'b0001);
        frame(4'b0000);

        // Two DOWN presses within one frame collapse to one request.
        for (int i = 0; i < 2; i++) begin
            keys_raw[KEY_DOWN] = 1'b1;
            tick(DB + 4);
            check_val("down_level", {28'd0, keys_level}, 32'h2);
            keys_raw[KEY_DOWN] = 1'b0;
            tick(DB + 4);
        end
        frame(4'b0010);

        // UP and DOWN together are both issued.
        keys_raw[1:0] = 2'b11;
        tick(DB + 4);
        keys_raw[1:0] = 2'b00;
        tick(DB + 4);
        frame(4'b0011);

        // RIGHT settles in the frame-edge cycle: issued now, not carried over.
        keys_raw[KEY_RIGHT] = 1'b1;
        tick(DB + 2);
        check_val("right_level", {28'd0, keys_level}, 32'h8);
        frame(4'b1000);
        keys_raw[KEY_RIGHT] = 1'b0;
        tick(DB + 4);
        frame(4'b0000);

        // UP pending when reset hits; DOWN held through reset is re-debounced.
        keys_raw[KEY_UP] = 1'b1;
        tick(DB + 4);
        check_val("pre_reset_level", {28'd0, keys_level}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_val("async_reset_op", {28'd0, op_keys}, 32'd0);
        check_val("async_reset_level", {28'd0, keys_level}, 32'd0);
        keys_raw[KEY_UP]   = 1'b0;
        keys_raw[KEY_DOWN] = 1'b1;
        tick(3);
        rst  = 1'b0;
        mark = cyc;
        tick(DB + 1);
        check_val("post_reset_level_early", {28'd0, keys_level}, 32'd0);
        tick(1);
        check_val("post_reset_level", {28'd0, keys_level}, 32'h2);
        check_val("post_reset_delay", cyc - mark, DB + 2);
        keys_raw[KEY_DOWN] = 1'b0;
        tick(DB + 4);
        frame(4'b0010);

        // LEFT held across eleven frames: auto-repeat pattern or a single pulse.
        keys_raw[KEY_LEFT] = 1'b1;
        tick(DB + 6);
        for (int f = 1; f <= 11; f++) begin
            exp = ((f == 1) || (REP_EN && f >= 5 && (f % 2) == 1)) ? 4'b0100 : 4'b0000;
            frame(exp);
            tick(5);
        end
        keys_raw[KEY_LEFT] = 1'b0;
        tick(DB + 4);
        frame(4'b0000);

        tick(5);
        check_val("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
